// File: rtl/rx_packet_parser.sv
// Purpose: receive-side parser for 7-word Q-table update packets; validates and latches fields for QTableUpdatev3.
// Latency: final word (w6) accepted at edge N -> f* updated and en high in cycle N+1; rx_error also reported in cycle N+1.
// Backpressure: rx_ready low from ISSUE until done is seen in WAIT_DONE, and during the reset cycle.
//
// Ports:
//   clk, nrst            clock; synchronous active-high reset
//   rx_valid/rx_data/rx_last/rx_ready   receive word stream (transfer on rx_valid & rx_ready)
//   fPacketType..fKnownCH               committed packet fields, stable until the next commit
//   en                                  one-cycle start pulse to the update stage
//   done                                update stage finished (only honoured in WAIT_DONE)
//   rx_error                            one-cycle pulse for a malformed (bad length) packet
//   pkt_accepted/pkt_dropped            saturating statistics, present only with PARSER_STATS_EN
// Optional feature macro: PARSER_STATS_EN
module rx_packet_parser #(
    parameter int                    WORD_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] NODE_ID     = '0,
    parameter logic [7:0]            ACCEPT_MASK = 8'hFE
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_last,
    output logic                  rx_ready,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fClusterID,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fKnownCH,
    output logic                  en,
    input  logic                  done,
    output logic                  rx_error
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0]           pkt_accepted,
    output logic [15:0]           pkt_dropped
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIELDS,
        S_FLUSH,
        S_ISSUE,
        S_WAIT_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  drop_d;
    logic                  commit_d;
    logic                  sh_we;
    logic                  xfer;
    // Shadow words w0..w5; w6 (knownCH) goes straight to its output on commit.
    logic [WORD_WIDTH-1:0] sh_q [6];
    logic [2:0]            f_type_q;
    logic [WORD_WIDTH-1:0] f_src_q, f_hops_q, f_clu_q, f_nrg_q, f_qv_q, f_kch_q;

    assign rx_ready = !nrst && (state_q == S_IDLE || state_q == S_FIELDS || state_q == S_FLUSH);
    assign xfer     = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        drop_d   = 1'b0;
        commit_d = 1'b0;
        sh_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (rx_last) begin
                        err_d = 1'b1;
                    end else begin
                        sh_we   = 1'b1;
                        cnt_d   = 3'd1;
                        state_d = S_FIELDS;
                    end
                end
            end
            S_FIELDS: begin
                if (xfer) begin
                    if (cnt_q == 3'd6) begin
                        cnt_d = 3'd0;
                        if (!rx_last) begin
                            // Overlong packet: report now, swallow the tail.
                            err_d   = 1'b1;
                            state_d = S_FLUSH;
                        end else if (ACCEPT_MASK[sh_q[0][2:0]] && (sh_q[1] != NODE_ID)) begin
                            commit_d = 1'b1;
                            state_d  = S_ISSUE;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (rx_last) begin
                        err_d   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        sh_we = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (xfer && rx_last) begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            err_q    <= 1'b0;
            f_type_q <= 3'd0;
            f_src_q  <= '0;
            f_hops_q <= '0;
            f_clu_q  <= '0;
            f_nrg_q  <= '0;
            f_qv_q   <= '0;
            f_kch_q  <= '0;
            for (int i = 0; i < 6; i++) begin
                sh_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < 6; i++) begin
                if (sh_we && (cnt_q == 3'(i))) begin
                    sh_q[i] <= rx_data;
                end
            end
            // Outputs load on the edge entering ISSUE so they are valid alongside en.
            if (commit_d) begin
                f_type_q <= sh_q[0][2:0];
                f_src_q  <= sh_q[1];
                f_hops_q <= sh_q[2];
                f_clu_q  <= sh_q[3];
                f_nrg_q  <= sh_q[4];
                f_qv_q   <= sh_q[5];
                f_kch_q  <= rx_data;
            end
        end
    end

    assign en          = (state_q == S_ISSUE);
    assign rx_error    = err_q;
    assign fPacketType = f_type_q;
    assign fSourceID   = f_src_q;
    assign fSourceHops = f_hops_q;
    assign fClusterID  = f_clu_q;
    assign fEnergyLeft = f_nrg_q;
    assign fQValue     = f_qv_q;
    assign fKnownCH    = f_kch_q;

`ifdef PARSER_STATS_EN
    logic [15:0] acc_q, drp_q;

    always_ff @(posedge clk) begin
        if (nrst) begin
            acc_q <= 16'd0;
            drp_q <= 16'd0;
        end else begin
            if ((state_q == S_ISSUE) && (acc_q != 16'hFFFF)) begin
                acc_q <= acc_q + 16'd1;
            end
            if ((err_d || drop_d) && (drp_q != 16'hFFFF)) begin
                drp_q <= drp_q + 16'd1;
            end
        end
    end

    assign pkt_accepted = acc_q;
    assign pkt_dropped  = drp_q;
`endif

endmodule

// File: tb/tb_rx_packet_parser.sv
module tb_rx_packet_parser;

    logic        clk = 1'b0;
    logic        nrst;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_last;
    logic        rx_ready;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
    logic        en;
    logic        done;
    logic        rx_error;
`ifdef PARSER_STATS_EN
    logic [15:0] pkt_accepted, pkt_dropped;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_packet_parser dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .fPacketType (fPacketType),
        .fSourceID   (fSourceID),
        .fSourceHops (fSourceHops),
        .fClusterID  (fClusterID),
        .fEnergyLeft (fEnergyLeft),
        .fQValue     (fQValue),
        .fKnownCH    (fKnownCH),
        .en          (en),
        .done        (done),
        .rx_error    (rx_error)
`ifdef PARSER_STATS_EN
        ,
        .pkt_accepted(pkt_accepted),
        .pkt_dropped (pkt_dropped)
`endif
    );

    logic [98:0] fields;
    assign fields = {fPacketType, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH};

    localparam logic [98:0] FIELDS_A = {3'd5, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15};
    localparam logic [98:0] FIELDS_B = {3'd2, 16'd9, 16'd4, 16'd6, 16'd100, 16'd200, 16'd33};

    // One word transfer; returns at #1 after the transfer edge with rx_valid dropped.
    task automatic xfer(input logic [15:0] d, input logic l);
        int t;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rx_ready && t < 50);
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout rx_ready=%b required 1", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] w [9], input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                @(posedge clk);
                #1;
            end
            xfer(w[i], (i == n - 1));
        end
    endtask

    // Complete an ISSUE cycle: done held across ISSUE (ignored) and WAIT_DONE.
    task automatic finish_issue();
        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 16'd0;
        rx_last = 1'b0;
        done = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", rx_ready); end
        checks++;
        if ({en, rx_error} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b required 00", {en, rx_error}); end
        checks++;
        if (fields !== 99'd0) begin errors++; $display("FAIL reset_fields got %h required 0", fields); end
        nrst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b required 1", rx_ready); end
    endtask

    task automatic test_valid();
        logic [15:0] w [9];
        w = '{16'd5, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if (en !== 1'b1) begin errors++; $display("FAIL valid_en got %b required 1", en); end
        checks++;
        if (fields !== FIELDS_A) begin errors++; $display("FAIL valid_fields got %h required %h", fields, FIELDS_A); end
        checks++;
        if ({rx_ready, rx_error} !== 2'b00) begin errors++; $display("FAIL valid_issue_ready_err got %b required 00", {rx_ready, rx_error}); end
        done = 1'b1;                       // ignored while in ISSUE
        @(posedge clk);
        #1;
        done = 1'b0;
        checks++;
        if ({en, rx_ready} !== 2'b00) begin errors++; $display("FAIL valid_wait got en,ready=%b required 00", {en, rx_ready}); end
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL valid_hold_ready got %b required 0", rx_ready); end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL valid_after_done_ready got %b required 1", rx_ready); end
        checks++;
        if (fields !== FIELDS_A) begin errors++; $display("FAIL valid_fields_stable got %h required %h", fields, FIELDS_A); end
    endtask

    task automatic test_short();
        logic [15:0] w [9];
        xfer(16'd5, 1'b1);                 // rx_last on w0
        checks++;
        if ({rx_error, en} !== 2'b10) begin errors++; $display("FAIL short_w0 got err,en=%b required 10", {rx_error, en}); end
        w = '{16'd5, 16'd7, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        send_pkt(w, 4, 1'b0);
        checks++;
        if ({rx_error, en} !== 2'b10) begin errors++; $display("FAIL short_w3 got err,en=%b required 10", {rx_error, en}); end
        @(posedge clk);
        #1;
        checks++;
        if ({rx_error, en} !== 2'b00) begin errors++; $display("FAIL short_pulse_end got err,en=%b required 00", {rx_error, en}); end
        checks++;
        if (fields !== FIELDS_A) begin errors++; $display("FAIL short_fields got %h required %h", fields, FIELDS_A); end
        w = '{16'hFFFA, 16'd9, 16'd4, 16'd6, 16'd100, 16'd200, 16'd33, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if ({en, fields} !== {1'b1, FIELDS_B}) begin errors++; $display("FAIL short_next_pkt got en=%b f=%h required 1 %h", en, fields, FIELDS_B); end
        finish_issue();
    endtask

    task automatic test_long();
        logic [15:0] w [9];
        w = '{16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        for (int i = 0; i < 7; i++) xfer(w[i], 1'b0);
        checks++;
        if ({rx_error, en} !== 2'b10) begin errors++; $display("FAIL long_w6 got err,en=%b required 10", {rx_error, en}); end
        xfer(w[7], 1'b0);
        checks++;
        if ({rx_error, en, rx_ready} !== 3'b001) begin errors++; $display("FAIL long_w7 got err,en,rdy=%b required 001", {rx_error, en, rx_ready}); end
        xfer(w[8], 1'b1);
        checks++;
        if ({rx_error, en} !== 2'b00) begin errors++; $display("FAIL long_w8 got err,en=%b required 00", {rx_error, en}); end
        checks++;
        if (fields !== FIELDS_B) begin errors++; $display("FAIL long_fields got %h required %h", fields, FIELDS_B); end
        w = '{16'd5, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if ({en, fields} !== {1'b1, FIELDS_A}) begin errors++; $display("FAIL long_next_pkt got en=%b f=%h required 1 %h", en, fields, FIELDS_A); end
        finish_issue();
    endtask

    task automatic test_filter();
        logic [15:0] w [9];
        w = '{16'd0, 16'd9, 16'd4, 16'd6, 16'd100, 16'd200, 16'd33, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if ({en, rx_error, rx_ready} !== 3'b001) begin errors++; $display("FAIL filter_type0 got en,err,rdy=%b required 001", {en, rx_error, rx_ready}); end
        w = '{16'd5, 16'd0, 16'd4, 16'd6, 16'd100, 16'd200, 16'd33, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if ({en, rx_error, rx_ready} !== 3'b001) begin errors++; $display("FAIL filter_own_id got en,err,rdy=%b required 001", {en, rx_error, rx_ready}); end
        @(posedge clk);
        #1;
        checks++;
        if ({en, fields} !== {1'b0, FIELDS_A}) begin errors++; $display("FAIL filter_fields got en=%b f=%h required 0 %h", en, fields, FIELDS_A); end
`ifdef PARSER_STATS_EN
        checks++;
        if ({pkt_accepted, pkt_dropped} !== {16'd3, 16'd5}) begin errors++; $display("FAIL filter_stats got acc=%0d drop=%0d required 3 5", pkt_accepted, pkt_dropped); end
`endif
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] w [9];
        w = '{16'd2, 16'd9, 16'd4, 16'd6, 16'd100, 16'd200, 16'd33, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b0);
        checks++;
        if (en !== 1'b1) begin errors++; $display("FAIL rstw_en got %b required 1", en); end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({en, rx_ready, fields} !== 100'd0) begin errors++; $display("FAIL rstw_cleared got en=%b rdy=%b f=%h required all 0", en, rx_ready, fields); end
`ifdef PARSER_STATS_EN
        checks++;
        if ({pkt_accepted, pkt_dropped} !== 32'd0) begin errors++; $display("FAIL rstw_stats got acc=%0d drop=%0d required 0 0", pkt_accepted, pkt_dropped); end
`endif
        nrst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL rstw_release_ready got %b required 1", rx_ready); end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        checks++;
        if ({en, rx_error, rx_ready} !== 3'b001) begin errors++; $display("FAIL rstw_stray_done got en,err,rdy=%b required 001", {en, rx_error, rx_ready}); end
    endtask

    task automatic test_gaps();
        logic [15:0] w [9];
        w = '{16'd5, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 16'd0, 16'd0};
        send_pkt(w, 7, 1'b1);
        checks++;
        if ({en, fields} !== {1'b1, FIELDS_A}) begin errors++; $display("FAIL gaps_pkt got en=%b f=%h required 1 %h", en, fields, FIELDS_A); end
        finish_issue();
        checks++;
        if ({en, rx_ready} !== 2'b01) begin errors++; $display("FAIL gaps_done got en,rdy=%b required 01", {en, rx_ready}); end
`ifdef PARSER_STATS_EN
        checks++;
        if ({pkt_accepted, pkt_dropped} !== {16'd1, 16'd0}) begin errors++; $display("FAIL gaps_stats got acc=%0d drop=%0d required 1 0", pkt_accepted, pkt_dropped); end
`endif
    endtask

    initial begin
        test_reset();
        test_valid();
        test_short();
        test_long();
        test_filter();
        test_reset_in_wait();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
